// File: rtl/rvfi_emitter_if.sv
// Retire-side bus of the RVFI emitter: two lanes of retired packets plus one shared ready.
// valid/ready: a lane transfers on a rising edge where its ret_valid bit and ret_ready are both 1;
// raising a ret_valid bit while ret_ready is 0 is a protocol violation, not a stall request.
interface rvfi_emitter_if;
   logic [1:0]         ret_valid;
   logic [1:0][310:0]  ret_pkt;
   logic               ret_ready;

   modport master (output ret_valid, output ret_pkt, input ret_ready);
   modport slave  (input ret_valid, input ret_pkt, output ret_ready);
endinterface

// File: rtl/rvfi_emitter.sv
// Buffers up to two retired instructions per cycle, numbers them, and emits one sanitized
// RVFI commit per cycle; stops for good on a self-looping instruction.
module rvfi_emitter #(
   parameter int DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   rvfi_emitter_if.slave        ret,
   output logic                 valid,
   output logic [63:0]          order,
   output logic [310:0]         rvfi_pkt,
   output logic                 halt,
   output logic                 error
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = 311;
   localparam int EW = 64 + PW;
   localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

   typedef struct packed {
      logic [31:0] inst;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [31:0] rs1_rdata;
      logic [31:0] rs2_rdata;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
      logic [31:0] pc_rdata;
      logic [31:0] pc_wdata;
      logic [31:0] mem_addr;
      logic [3:0]  mem_rmask;
      logic [3:0]  mem_wmask;
      logic [31:0] mem_rdata;
      logic [31:0] mem_wdata;
   } pkt_t;

   logic [EW-1:0]  mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [CW-1:0]  count;
   logic [CW-1:0]  count_next;
   logic [63:0]    order_cnt;
   logic           ready_q;
   logic           acc0;
   logic           acc1;
   logic [1:0]     n_push;
   logic           self_loop;
   logic           pop;
   logic           halt_next;
   logic           proto_err;
   pkt_t           head_pkt;
   pkt_t           out_pkt;
   logic [63:0]    head_order;

   function automatic pkt_t sanitize(input pkt_t p);
      pkt_t s;
      s = p;
      if (p.rs1_addr == '0) s.rs1_rdata = '0;
      if (p.rs2_addr == '0) s.rs2_rdata = '0;
      if (p.rd_addr == '0)  s.rd_wdata  = '0;
      for (int b = 0; b < 4; b++) begin
         if (!p.mem_rmask[b]) s.mem_rdata[8*b +: 8] = '0;
         if (!p.mem_wmask[b]) s.mem_wdata[8*b +: 8] = '0;
      end
      s.mem_addr = (p.mem_rmask == '0 && p.mem_wmask == '0) ? '0 : {p.mem_addr[31:2], 2'b00};
      return s;
   endfunction

   assign ret.ret_ready = ready_q;

   assign acc0   = ret.ret_valid[0] & ready_q & ~halt;
   assign acc1   = ret.ret_valid[1] & ready_q & ~halt;
   assign n_push = {1'b0, acc0} + {1'b0, acc1};

   assign head_pkt   = mem[rd_ptr][PW-1:0];
   assign head_order = mem[rd_ptr][EW-1:PW];
   assign out_pkt    = rvfi_pkt;

   // A self-loop being emitted right now already blocks the next pop, so nothing queued
   // behind it can slip out during the cycle before halt registers.
   assign self_loop  = valid & (out_pkt.pc_rdata == out_pkt.pc_wdata);
   assign pop        = (count != '0) & ~halt & ~self_loop;
   assign count_next = count + CW'(n_push) - CW'(pop);
   assign halt_next  = halt | self_loop;
   assign proto_err  = (|ret.ret_valid) & ~ready_q & ~halt;

   // Storage carries no reset; pointers and count alone define which entries are live.
   always_ff @(posedge clk) begin
      if (acc0) mem[wr_ptr] <= {order_cnt, ret.ret_pkt[0]};
      if (acc1) mem[wr_ptr + AW'(acc0)] <= {order_cnt + 64'(acc0), ret.ret_pkt[1]};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         order_cnt <= '0;
         ready_q   <= 1'b0;
         valid     <= 1'b0;
         order     <= '0;
         rvfi_pkt  <= '0;
         halt      <= 1'b0;
         error     <= 1'b0;
      end else begin
         wr_ptr    <= wr_ptr + AW'(n_push);
         order_cnt <= order_cnt + 64'(n_push);
         count     <= count_next;
         valid     <= pop;
         halt      <= halt_next;
         error     <= error | proto_err;
         // Registered from next-state so ready rises one edge after reset release.
         ready_q   <= (count_next <= READY_MAX) & ~halt_next;
         if (pop) begin
            rd_ptr   <= rd_ptr + AW'(1);
            order    <= head_order;
            rvfi_pkt <= sanitize(head_pkt);
         end
      end
   end
endmodule
